// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: global stalls, per-stage hazards and redirects, precise
// exceptions, with pending-event capture. Perf counters built under PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned NSTAGE    = 7,
  parameter int unsigned NGLB      = 4,
  parameter int unsigned EXC_STAGE = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NGLB-1:0]   glb_stall_req,
  input  logic [NSTAGE-1:0] stall_req,
  input  logic [NSTAGE-1:0] redirect_req,
  input  logic              exc_req,
  output logic [NSTAGE-1:0] stage_wr,
  output logic [NSTAGE-1:0] stage_flush,
  output logic [NSTAGE-1:0] side_dis,
  output logic              fetch_req_valid,
  output logic              mem_req_valid,
  output logic              icache_hold,
  output logic              dcache_hold,
  output logic [CNT_W-1:0]  cnt_glb,
  output logic [CNT_W-1:0]  cnt_haz,
  output logic [CNT_W-1:0]  cnt_flush
);

  localparam logic [NSTAGE-1:0] StallMask = {1'b0, {(NSTAGE-2){1'b1}}, 1'b0};
  localparam logic [NSTAGE-1:0] RedirMask = {{(NSTAGE-1){1'b1}}, 1'b0};
  localparam logic [NSTAGE-1:0] ExcFlush  =
      {{(NSTAGE-EXC_STAGE-1){1'b0}}, {EXC_STAGE{1'b1}}, 1'b0};
  localparam logic [NSTAGE-1:0] ExcSide   =
      {{(NSTAGE-EXC_STAGE-1){1'b0}}, 1'b1, {EXC_STAGE{1'b0}}};
  localparam logic [NSTAGE-1:0] GlbSide   =
      {{(NSTAGE-EXC_STAGE){1'b1}}, {EXC_STAGE{1'b0}}};

  logic              pend_exc_q, pend_exc_d;
  logic [NSTAGE-1:0] pend_redir_q, pend_redir_d;

  logic              glb;
  logic              exc_e;
  logic [NSTAGE-1:0] stall_v;
  logic [NSTAGE-1:0] redir_req_v;
  logic [NSTAGE-1:0] redir_e;

  logic              hit;
  logic              hit_stall;
  int                hit_idx;

  logic              is_glb, is_exc, is_stall, is_redir;

  logic [NSTAGE-1:0] stall_wr, stall_fl, stall_sd, redir_fl;

  // Keeps only the oldest (highest-index) set bit.
  function automatic logic [NSTAGE-1:0] keep_oldest(input logic [NSTAGE-1:0] v);
    logic [NSTAGE-1:0] r;
    r = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  assign glb         = |glb_stall_req;
  assign exc_e       = exc_req | pend_exc_q;
  assign stall_v     = stall_req & StallMask;
  assign redir_req_v = redirect_req & RedirMask;
  assign redir_e     = redir_req_v | pend_redir_q;

  always_comb begin
    hit       = 1'b0;
    hit_stall = 1'b0;
    hit_idx   = 0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (stall_v[i] || redir_e[i]) begin
        hit       = 1'b1;
        hit_stall = stall_v[i];
        hit_idx   = i;
      end
    end
  end

  always_comb begin
    stall_wr = '0;
    stall_fl = '0;
    stall_sd = '0;
    redir_fl = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      stall_wr[i] = (i > hit_idx);
      stall_fl[i] = (i == hit_idx + 1);
      stall_sd[i] = (i == hit_idx);
      redir_fl[i] = (i >= 1) && (i <= hit_idx);
    end
  end

  assign is_glb   = glb;
  assign is_exc   = !glb && exc_e;
  assign is_stall = !glb && !exc_e && hit && hit_stall;
  assign is_redir = !glb && !exc_e && hit && !hit_stall;

  always_comb begin
    stage_wr        = '1;
    stage_flush     = '0;
    side_dis        = '0;
    fetch_req_valid = 1'b1;
    mem_req_valid   = 1'b1;
    icache_hold     = 1'b0;
    dcache_hold     = 1'b0;
    if (rst) begin
      stage_wr        = '0;
      stage_flush     = '1;
      side_dis        = '1;
      fetch_req_valid = 1'b0;
      mem_req_valid   = 1'b0;
    end else if (is_glb) begin
      stage_wr        = '0;
      side_dis        = GlbSide;
      fetch_req_valid = 1'b0;
      icache_hold     = 1'b1;
      dcache_hold     = 1'b1;
    end else if (is_exc) begin
      stage_flush     = ExcFlush;
      side_dis        = ExcSide;
      fetch_req_valid = 1'b0;
      mem_req_valid   = 1'b0;
    end else if (is_stall) begin
      stage_wr        = stall_wr;
      stage_flush     = stall_fl;
      side_dis        = stall_sd;
      fetch_req_valid = 1'b0;
      icache_hold     = 1'b1;
    end else if (is_redir) begin
      stage_flush     = redir_fl;
      fetch_req_valid = 1'b0;
    end
  end

  always_comb begin
    pend_exc_d   = pend_exc_q;
    pend_redir_d = pend_redir_q;
    if (is_glb) begin
      if (exc_req) begin
        pend_exc_d = 1'b1;
      end
      // A redirect behind a known exception is moot: the exception flushes it anyway.
      if (!exc_e) begin
        pend_redir_d = keep_oldest(pend_redir_q | redir_req_v);
      end
    end else if (is_exc) begin
      pend_exc_d   = 1'b0;
      pend_redir_d = '0;
    end else if (is_redir) begin
      pend_redir_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_exc_q   <= 1'b0;
      pend_redir_q <= '0;
    end else begin
      pend_exc_q   <= pend_exc_d;
      pend_redir_q <= pend_redir_d;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] cnt_glb_q, cnt_haz_q, cnt_flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_glb_q   <= '0;
      cnt_haz_q   <= '0;
      cnt_flush_q <= '0;
    end else begin
      if (is_glb && (cnt_glb_q != '1)) begin
        cnt_glb_q <= cnt_glb_q + CNT_W'(1);
      end
      if (is_stall && (cnt_haz_q != '1)) begin
        cnt_haz_q <= cnt_haz_q + CNT_W'(1);
      end
      if ((is_exc || is_redir) && (cnt_flush_q != '1)) begin
        cnt_flush_q <= cnt_flush_q + CNT_W'(1);
      end
    end
  end

  assign cnt_glb   = cnt_glb_q;
  assign cnt_haz   = cnt_haz_q;
  assign cnt_flush = cnt_flush_q;
`else
  assign cnt_glb   = '0;
  assign cnt_haz   = '0;
  assign cnt_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (NSTAGE 7, EXC_STAGE 4, CNT_W 4).
module tb_pipe_hazard_ctrl;

  localparam int unsigned NSTAGE = 7;
  localparam int unsigned NGLB   = 4;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NGLB-1:0]   glb_stall_req;
  logic [NSTAGE-1:0] stall_req;
  logic [NSTAGE-1:0] redirect_req;
  logic              exc_req;
  logic [NSTAGE-1:0] stage_wr, stage_flush, side_dis;
  logic              fetch_req_valid, mem_req_valid, icache_hold, dcache_hold;
  logic [CNT_W-1:0]  cnt_glb, cnt_haz, cnt_flush;

  int n_cmp = 0;
  int n_err = 0;

  pipe_hazard_ctrl #(
    .NSTAGE   (NSTAGE),
    .NGLB     (NGLB),
    .EXC_STAGE(4),
    .CNT_W    (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .glb_stall_req  (glb_stall_req),
    .stall_req      (stall_req),
    .redirect_req   (redirect_req),
    .exc_req        (exc_req),
    .stage_wr       (stage_wr),
    .stage_flush    (stage_flush),
    .side_dis       (side_dis),
    .fetch_req_valid(fetch_req_valid),
    .mem_req_valid  (mem_req_valid),
    .icache_hold    (icache_hold),
    .dcache_hold    (dcache_hold),
    .cnt_glb        (cnt_glb),
    .cnt_haz        (cnt_haz),
    .cnt_flush      (cnt_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Checks every control output; called mid-cycle, away from the rising edge.
  task automatic expect_out(input string tag, input logic [NSTAGE-1:0] wr,
                            input logic [NSTAGE-1:0] fl, input logic [NSTAGE-1:0] sd,
                            input logic fv, input logic mv, input logic ih, input logic dh);
    chk({tag, ".wr"},    32'(stage_wr),        32'(wr));
    chk({tag, ".flush"}, 32'(stage_flush),     32'(fl));
    chk({tag, ".side"},  32'(side_dis),        32'(sd));
    chk({tag, ".fetch"}, 32'(fetch_req_valid), 32'(fv));
    chk({tag, ".mem"},   32'(mem_req_valid),   32'(mv));
    chk({tag, ".ihold"}, 32'(icache_hold),     32'(ih));
    chk({tag, ".dhold"}, 32'(dcache_hold),     32'(dh));
  endtask

  task automatic drive(input logic [NGLB-1:0] g, input logic [NSTAGE-1:0] s,
                       input logic [NSTAGE-1:0] r, input logic e);
    glb_stall_req = g;
    stall_req     = s;
    redirect_req  = r;
    exc_req       = e;
    #4;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(4'b0, 7'b0, 7'b0, 1'b0);
    expect_out("reset", 7'b0000000, 7'b1111111, 7'b1111111, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    tick;
    rst = 1'b0;

    drive(4'b0, 7'b0, 7'b0, 1'b0);
    expect_out("idle", 7'b1111111, 7'b0, 7'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick;

    for (int c = 0; c < 3; c++) begin
      drive(4'b0, 7'b0000100, 7'b0, 1'b0);
      expect_out("stall2", 7'b1111000, 7'b0001000, 7'b0000100, 1'b0, 1'b1, 1'b1, 1'b0);
      tick;
    end

    drive(4'b0, 7'b0, 7'b0001000, 1'b0);
    expect_out("redir3", 7'b1111111, 7'b0001110, 7'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick;
    drive(4'b0, 7'b0, 7'b0, 1'b0);
    expect_out("post_redir", 7'b1111111, 7'b0, 7'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick;

    // Exception pulse in the second of five global-stall cycles is held until release.
    for (int c = 0; c < 5; c++) begin
      drive(4'b0001, 7'b0, 7'b0, (c == 1));
      expect_out("glb_exc", 7'b0, 7'b0, 7'b1110000, 1'b0, 1'b1, 1'b1, 1'b1);
      tick;
    end
    drive(4'b0, 7'b0, 7'b0, 1'b0);
    expect_out("deferred_exc", 7'b1111111, 7'b0011110, 7'b0010000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    drive(4'b0, 7'b0, 7'b0, 1'b0);
    expect_out("post_exc", 7'b1111111, 7'b0, 7'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick;

    drive(4'b0, 7'b0000100, 7'b0001000, 1'b0);
    expect_out("st2_rd3", 7'b1111111, 7'b0001110, 7'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick;
    drive(4'b0, 7'b0001000, 7'b0001000, 1'b0);
    expect_out("st3_rd3", 7'b1110000, 7'b0010000, 7'b0001000, 1'b0, 1'b1, 1'b1, 1'b0);
    tick;
    drive(4'b0, 7'b0, 7'b0000100, 1'b1);
    expect_out("exc_rd2", 7'b1111111, 7'b0011110, 7'b0010000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    drive(4'b0, 7'b0, 7'b0, 1'b0);
    expect_out("post_exc_rd2", 7'b1111111, 7'b0, 7'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick;

    // Capture a pending redirect at stage 3, then reset mid-stall.
    drive(4'b0001, 7'b0, 7'b0001000, 1'b0);
    tick;
    drive(4'b0001, 7'b0, 7'b0, 1'b0);
    rst = 1'b1;
    #1;
    expect_out("rst_mid", 7'b0000000, 7'b1111111, 7'b1111111, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    rst = 1'b0;
    drive(4'b0, 7'b0, 7'b0, 1'b0);
    expect_out("after_rst", 7'b1111111, 7'b0, 7'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("cnt_glb_rst",   32'(cnt_glb),   32'd0);
    chk("cnt_haz_rst",   32'(cnt_haz),   32'd0);
    chk("cnt_flush_rst", 32'(cnt_flush), 32'd0);
    tick;

    for (int c = 0; c < 20; c++) begin
      drive(4'b0100, 7'b0, 7'b0, 1'b0);
      tick;
    end
    drive(4'b0, 7'b0, 7'b0, 1'b0);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    chk("cnt_glb_sat", 32'(cnt_glb), 32'd15);
`else
    chk("cnt_glb_off", 32'(cnt_glb), 32'd0);
`endif
    chk("cnt_haz_sat", 32'(cnt_haz), 32'd0);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline stall/flush controller for the in-order core; generalises the fixed-stage control unit to NSTAGE stages with per-stage hazard stalls, per-stage redirects and a configurable exception stage. Adds sequential pending-event capture, so single-cycle redirect and exception pulses arriving during a global (cache/TLB/mul-div) stall are held and applied on release. Optional saturating performance counters. Sits beside the datapath and drives every stage register's write-enable and flush.

## Interface
- NSTAGE, 7 — pipeline registers; index 0 = PC/pre-fetch, NSTAGE-1 = writeback
- NGLB, 4 — global stall sources (dcache, dtlb, icache, itlb/muldiv)
- EXC_STAGE, 4 — stage that raises precise exceptions (1..NSTAGE-2)
- CNT_W, 32 — perf counter width
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- glb_stall_req  in  NGLB  any bit freezes the whole pipe
- stall_req  in  NSTAGE  stage k must hold (data hazard); bits 0 and NSTAGE-1 ignored
- redirect_req  in  NSTAGE  1-cycle pulse: stage k resolved a wrong fetch path; bit 0 ignored
- exc_req  in  1  1-cycle pulse: exception at EXC_STAGE
- stage_wr  out  NSTAGE  stage register i loads on this edge
- stage_flush  out  NSTAGE  stage register i loads a bubble (valid cleared) on this edge
- side_dis  out  NSTAGE  suppress side effects (HI/LO, CP0, store) of stage i this cycle
- fetch_req_valid  out  1  issue new I-cache request
- mem_req_valid  out  1  issue D-cache request
- icache_hold, dcache_hold  out  1  cache must keep returned data until accepted
- cnt_glb, cnt_haz, cnt_flush  out  CNT_W  perf counters

## Operation
- State: pend_exc (1 bit), pend_redir (NSTAGE bits, at most one set), counters.
- Effective events: exc_e = exc_req | pend_exc; redir_e = redirect_req | pend_redir.
- Priority per cycle, first match wins:
  1. Global (|glb_stall_req): stage_wr = 0, stage_flush = 0, side_dis[EXC_STAGE..NSTAGE-1] = 1, both holds = 1. exc_req sets pend_exc; redirect_req sets pend_redir (older stage replaces younger; discarded if exc_e).
  2. Exception: stage_wr = all 1; stage_flush[1..EXC_STAGE] = 1; side_dis[EXC_STAGE] = 1; mem_req_valid = 0; pend_exc and pend_redir clear.
  3. Hazard/redirect: take the highest index k having stall_req[k] or redir_e[k]; on a tie at k, stall wins.
     - Stall at k: stage_wr[0..k] = 0; stage_flush[k+1] = 1; stage_wr[k+1..] = 1; side_dis[k] = 1; icache_hold = 1. Any younger redirect pulse is dropped (it re-asserts after release).
     - Redirect at k: stage_wr = all 1; stage_flush[1..k] = 1; pend_redir clears.
  4. Normal: stage_wr = all 1, flush = 0.
- stage_flush[i] = 1 implies stage_wr[i] = 1.
- fetch_req_valid = 0 whenever any stall, exception, redirect or pending event is active; else 1. mem_req_valid = 1 except case 2.

## Timing
- All outputs are combinational from inputs and state: zero latency.
- Pending event applies in the first cycle glb_stall_req = 0, through the same priority.
- Reset (async): pend_exc = 0, pend_redir = 0, counters = 0. While rst is high: stage_wr = 0, stage_flush = all 1, side_dis = all 1, fetch_req_valid = mem_req_valid = 0, holds = 0. Reset during a stall discards pending events.
- exc_req and redirect_req in the same unstalled cycle: exception wins and the redirect is discarded.

## Configuration
- PIPE_HAZARD_CTRL_PERF_EN defined: cnt_glb increments each global-stall cycle, cnt_haz each case-3 stall cycle, cnt_flush each exception/redirect application. Counters saturate at all-ones and never wrap.
- Undefined: counters are not built and all cnt_* outputs are 0.

## Test plan
- Stall sequencing: stall_req[2] = 1 for 3 cycles, defaults. Each cycle: stage_wr = 7'b1111000, stage_flush[3] = 1, fetch_req_valid = 0.
- Redirect: redirect_req[3] pulse. Result: stage_wr = all 1, stage_flush = 7'b0001110.
- Deferred exception: glb_stall_req = 4'b0001 for 5 cycles, exc_req pulse in cycle 2. No flush during the stall. In the first free cycle: stage_flush = 7'b0011110, mem_req_valid = 0. Next cycle is normal.
- Conflicts:
  - stall_req[2] with redirect_req[3]: redirect wins.
  - stall_req[3] with redirect_req[3]: stall wins.
  - exc_req with redirect_req[2]: exception only.
- Reset: rst mid global stall holding pend_redir[3]. After release, no flush occurs and the counters read 0.
- Saturation (PERF_EN, CNT_W = 4): 20 global-stall cycles. cnt_glb = 15 and holds.
